// File: rtl/matmul_pkg.sv
// Shared constants for the matrix-multiply engine: controller state encoding,
// ceil-log2 helper and accumulator width derivation.
package matmul_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MAC   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  // K terms of full-precision products need clog2(K) guard bits.
  function automatic int acc_width(input int data_w, input int k_terms);
    return 2 * data_w + clog2(k_terms);
  endfunction

endpackage

// File: rtl/matmul_mac_lane.sv
// One result element: registered multiplier, signed accumulator and
// clamp/truncate stage with overflow detection.
module matmul_mac_lane
  import matmul_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int OUT_W    = 32,
  parameter int ACC_W    = 64,
  parameter int SATURATE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     mul_en,
  input  logic                     acc_en,
  input  logic                     out_en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic        [OUT_W-1:0]  out_data,
  output logic                     out_ovf
);

  localparam int PROD_W = 2 * DATA_W;
  localparam logic [OUT_W-1:0] OUT_MIN = OUT_W'(1) << (OUT_W - 1);
  localparam logic [OUT_W-1:0] OUT_MAX = ~OUT_MIN;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc;
  logic [ACC_W-OUT_W:0]     upper;
  logic                     fits;
  logic [OUT_W-1:0]         res;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod <= '0;
    end else if (mul_en) begin
      prod <= PROD_W'(a) * PROD_W'(b);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (acc_en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

  // The value fits in OUT_W bits exactly when the bits from OUT_W-1 upward are
  // a pure sign extension; that is the overflow test for both modes.
  assign upper = acc[ACC_W-1:OUT_W-1];
  assign fits  = (&upper) | ~(|upper);

  // NOTE: every output of a combinational block gets a value on every path
  // (default first), otherwise synthesis infers a latch.
  always_comb begin
    res = acc[OUT_W-1:0];
    if (!fits && SATURATE != 0) begin
      res = acc[ACC_W-1] ? OUT_MIN : OUT_MAX;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_ovf  <= 1'b0;
    end else if (out_en) begin
      out_data <= res;
      out_ovf  <= ~fits;
    end
  end

endmodule

// File: rtl/matmul_engine.sv
// Multi-cycle C = A x B engine: one MAC lane per output element, stepping
// through the K inner terms one per cycle with valid/ready handshakes.
module matmul_engine
  import matmul_pkg::*;
#(
  parameter int M        = 2,
  parameter int K        = 2,
  parameter int N        = 2,
  parameter int DATA_W   = 32,
  parameter int OUT_W    = 32,
  parameter int SATURATE = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_W*(M*K+K*N)-1:0]   in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [OUT_W*M*N-1:0]          out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_ovf
);

  localparam int ACC_W = acc_width(DATA_W, K);
  localparam int KW    = (K > 1) ? clog2(K) : 1;
  localparam int IN_W  = DATA_W * (M * K + K * N);

  logic [1:0]       state;
  logic [KW-1:0]    k;
  logic             drain_ph;
  logic             prod_vld;
  logic [IN_W-1:0]  opnd;
  logic             accept;
  logic             last_k;

  logic signed [DATA_W-1:0] a_el [M][K];
  logic signed [DATA_W-1:0] b_el [K][N];
  logic [OUT_W-1:0]         lane_res [M*N];
  logic                     lane_ovf [M*N];

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_HOLD);
  assign accept    = in_valid & in_ready;
  assign last_k    = (k == KW'(K - 1));

  // DRAIN spans two cycles: the final product is accumulated, then the
  // clamped result is registered, giving a K+2 cycle accept-to-valid latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      k        <= '0;
      drain_ph <= 1'b0;
      prod_vld <= 1'b0;
    end else begin
      prod_vld <= (state == ST_MAC);
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= ST_MAC;
            k     <= '0;
          end
        end
        ST_MAC: begin
          if (last_k) begin
            state    <= ST_DRAIN;
            drain_ph <= 1'b0;
          end else begin
            k <= k + KW'(1);
          end
        end
        ST_DRAIN: begin
          if (drain_ph) state <= ST_HOLD;
          drain_ph <= 1'b1;
        end
        default: begin
          if (out_ready) state <= ST_IDLE;
        end
      endcase
    end
  end

  // NOTE: the operand register is deliberately left without reset; it is
  // always loaded on acceptance before any lane reads it.
  always_ff @(posedge clk) begin
    if (accept) opnd <= in_data;
  end

  for (genvar r = 0; r < M; r++) begin : g_a_row
    for (genvar kk = 0; kk < K; kk++) begin : g_a_col
      assign a_el[r][kk] = opnd[(r*K + kk)*DATA_W +: DATA_W];
    end
  end

  for (genvar kk = 0; kk < K; kk++) begin : g_b_row
    for (genvar c = 0; c < N; c++) begin : g_b_col
      assign b_el[kk][c] = opnd[(M*K + kk*N + c)*DATA_W +: DATA_W];
    end
  end

  for (genvar r = 0; r < M; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      matmul_mac_lane #(
        .DATA_W  (DATA_W),
        .OUT_W   (OUT_W),
        .ACC_W   (ACC_W),
        .SATURATE(SATURATE)
      ) u_lane (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (accept),
        .mul_en  (state == ST_MAC),
        .acc_en  (prod_vld),
        .out_en  ((state == ST_DRAIN) && drain_ph),
        .a       (a_el[r][k]),
        .b       (b_el[k][c]),
        .out_data(lane_res[r*N + c]),
        .out_ovf (lane_ovf[r*N + c])
      );
    end
  end

  always_comb begin
    out_data = '0;
    out_ovf  = 1'b0;
    for (int i = 0; i < M*N; i++) begin
      out_data[i*OUT_W +: OUT_W] = lane_res[i];
      out_ovf                    = out_ovf | lane_ovf[i];
    end
  end

endmodule

// File: tb/tb_matmul_engine.sv
// Directed bench for matmul_engine across five parameterisations: basic,
// signed, saturate/truncate, backpressure, mid-operation reset and K=1.
module tb_matmul_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [4:0] iv;
  logic [4:0] ordy;
  wire  [4:0] ir;
  wire  [4:0] ov;
  wire  [4:0] of;

  logic [255:0] id0;
  wire  [127:0] od0;
  logic [127:0] id1;
  wire  [63:0]  od1;
  logic [127:0] id2;
  wire  [63:0]  od2;
  logic [255:0] id3;
  wire  [63:0]  od3;
  logic [191:0] id4;
  wire  [287:0] od4;

  int passed = 0;
  int total  = 0;

  matmul_engine u0 (
    .clk(clk), .rst_n(rst_n), .in_data(id0), .in_valid(iv[0]), .in_ready(ir[0]),
    .out_data(od0), .out_valid(ov[0]), .out_ready(ordy[0]), .out_ovf(of[0]));

  matmul_engine #(.M(2), .K(4), .N(2), .DATA_W(8), .OUT_W(16), .SATURATE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_data(id1), .in_valid(iv[1]), .in_ready(ir[1]),
    .out_data(od1), .out_valid(ov[1]), .out_ready(ordy[1]), .out_ovf(of[1]));

  matmul_engine #(.M(2), .K(4), .N(2), .DATA_W(8), .OUT_W(16), .SATURATE(0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_data(id2), .in_valid(iv[2]), .in_ready(ir[2]),
    .out_data(od2), .out_valid(ov[2]), .out_ready(ordy[2]), .out_ovf(of[2]));

  matmul_engine #(.M(2), .K(8), .N(2), .DATA_W(8), .OUT_W(16), .SATURATE(1)) u3 (
    .clk(clk), .rst_n(rst_n), .in_data(id3), .in_valid(iv[3]), .in_ready(ir[3]),
    .out_data(od3), .out_valid(ov[3]), .out_ready(ordy[3]), .out_ovf(of[3]));

  matmul_engine #(.M(3), .K(1), .N(3)) u4 (
    .clk(clk), .rst_n(rst_n), .in_data(id4), .in_valid(iv[4]), .in_ready(ir[4]),
    .out_data(od4), .out_valid(ov[4]), .out_ready(ordy[4]), .out_ovf(of[4]));

  task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic logic [511:0] od_of(input int u);
    case (u)
      0:       return 512'(od0);
      1:       return 512'(od1);
      2:       return 512'(od2);
      3:       return 512'(od3);
      default: return 512'(od4);
    endcase
  endfunction

  task automatic start(input int u, input bit early, input string tag);
    @(negedge clk);
    check({tag, "_in_ready"}, 512'(ir[u]), 512'(1));
    iv[u] = 1'b1;
    if (early) ordy[u] = 1'b1;
    @(posedge clk);
    #1 iv[u] = 1'b0;
  endtask

  task automatic wait_out(input int u, input int lat_exp, input string tag);
    int lat;
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!ov[u] && lat < 40);
    check({tag, "_latency"}, 512'(lat), 512'(lat_exp));
  endtask

  task automatic finish_out(input int u, input string tag);
    ordy[u] = 1'b1;
    @(posedge clk);
    #1 ordy[u] = 1'b0;
    check({tag, "_idle"}, 512'({ov[u], ir[u]}), 512'(2'b01));
  endtask

  task automatic run(input int u, input int lat_exp, input logic [511:0] c_exp,
                     input logic ovf_exp, input bit early, input string tag);
    start(u, early, tag);
    wait_out(u, lat_exp, tag);
    check({tag, "_c"}, od_of(u), c_exp);
    check({tag, "_ovf"}, 512'(of[u]), 512'(ovf_exp));
    finish_out(u, tag);
  endtask

  initial begin
    logic [511:0] exp0;
    int           highs;

    rst_n = 1'b0;
    iv    = '0;
    ordy  = '0;
    id0   = '0;
    id1   = '0;
    id2   = '0;
    id3   = '0;
    id4   = '0;
    #12;
    for (int u = 0; u < 5; u++) begin
      check($sformatf("reset_ctrl%0d", u), 512'({ov[u], ir[u], of[u]}), 512'(3'b010));
      check($sformatf("reset_data%0d", u), od_of(u), '0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic 2x2, accepted on the first edge after reset release.
    id0 = {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    run(0, 4, 512'({32'd50, 32'd43, 32'd22, 32'd19}), 1'b0, 1'b0, "basic");

    id0 = {32'd7, 32'd6, -32'sd5, 32'd4, -32'sd1, 32'd1, 32'd2, -32'sd3};
    run(0, 4, 512'({-32'sd12, -32'sd2, 32'd29, 32'd0}), 1'b0, 1'b0, "signed");

    id1 = {16{8'd127}};
    run(1, 6, 512'({4{16'h7FFF}}), 1'b1, 1'b0, "saturate");
    id2 = {16{8'd127}};
    run(2, 6, 512'({4{16'hFC04}}), 1'b1, 1'b0, "truncate");

    // Backpressure: hold result five cycles, inject an ignored operand set.
    id0 = {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    exp0 = 512'({32'd50, 32'd43, 32'd22, 32'd19});
    start(0, 1'b0, "bp");
    wait_out(0, 4, "bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 2) begin
        id0   = {32'd4, 32'd3, 32'd2, 32'd1, 32'd2, 32'd0, 32'd0, 32'd2};
        iv[0] = 1'b1;
      end
      @(posedge clk);
      #1 iv[0] = 1'b0;
      check($sformatf("bp_hold_c%0d", i), od_of(0), exp0);
      check($sformatf("bp_hold_ctrl%0d", i), 512'({ov[0], ir[0]}), 512'(2'b10));
    end
    @(negedge clk);
    finish_out(0, "bp");
    run(0, 4, 512'({32'd8, 32'd6, 32'd4, 32'd2}), 1'b0, 1'b0, "bp_next");

    // K=8 reference run, then reset in the middle of the next one.
    for (int kk = 0; kk < 8; kk++) begin
      id3[(0*8 + kk)*8 +: 8]      = 8'd1;
      id3[(1*8 + kk)*8 +: 8]      = 8'(kk + 1);
      id3[(16 + kk*2 + 0)*8 +: 8] = 8'd1;
      id3[(16 + kk*2 + 1)*8 +: 8] = 8'd2;
    end
    run(3, 10, 512'({16'd72, 16'd36, 16'd16, 16'd8}), 1'b0, 1'b0, "k8");

    for (int kk = 0; kk < 8; kk++) begin
      id3[(0*8 + kk)*8 +: 8]      = 8'd2;
      id3[(1*8 + kk)*8 +: 8]      = 8'hFF;
      id3[(16 + kk*2 + 0)*8 +: 8] = 8'd3;
      id3[(16 + kk*2 + 1)*8 +: 8] = 8'hFF;
    end
    start(3, 1'b0, "rst");
    ordy[3] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_ctrl", 512'({ov[3], ir[3], of[3]}), 512'(3'b010));
    check("rst_data", od_of(3), '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    highs = 0;
    repeat (12) begin
      @(posedge clk);
      #1 if (ov[3]) highs++;
    end
    ordy[3] = 1'b0;
    check("rst_no_valid", 512'(highs), 512'(0));
    run(3, 10, 512'({16'd8, 16'hFFE8, 16'hFFF0, 16'd48}), 1'b0, 1'b0, "rst_new");

    // K=1 outer product with out_ready raised before out_valid.
    id4 = {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    run(4, 3, 512'({32'd18, 32'd15, 32'd12, 32'd12, 32'd10, 32'd8, 32'd6, 32'd5, 32'd4}),
        1'b0, 1'b1, "k1");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
